multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle RV32I control FSM. Sequences fetch/decode/execute/memory/writeback over the shared datapath
//  (PC, IR, immediate generator, ALU, register file, single memory port). Decodes the opcode held in IR and
//  drives datapath selects, write enables and the memory request/acknowledge handshake.
//  Counts retired instructions. Traps on an illegal opcode or a memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles mem_req may stay high without mem_ack before bus error (>=1)
//  INSTRET_W    32   width of retired-instruction counter
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  opcode     in   7          IR[6:0]
//  br_taken   in   1          branch compare result from ALU, valid in EXEC
//  mem_ack    in   1          memory done; read data valid same cycle
//  mem_req    out  1          memory request, held until mem_ack
//  mem_we     out  1          1=store, 0=read
//  addr_sel   out  1          mem address: 0=PC, 1=ALU result
//  ir_we      out  1          load IR (and MDR) from mem read data
//  pc_we      out  1          update PC
//  pc_src     out  2          0=PC+4, 1=PC+imm, 2=ALU result & ~1
//  alu_a_sel  out  2          0=rs1, 1=PC, 2=zero
//  alu_b_sel  out  1          0=rs2, 1=imm
//  alu_op     out  2          0=add, 1=funct-decoded op, 2=branch compare
//  rf_we      out  1          register-file write
//  wb_sel     out  2          0=ALU, 1=MDR (load data), 2=PC+4
//  retire     out  1          1-cycle pulse when an instruction completes
//  instret    out  INSTRET_W  retired count, wraps to 0
//  illegal    out  1          sticky, illegal opcode trap
//  bus_err    out  1          sticky, memory timeout trap
// BEHAVIOUR
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded from state and opcode.
//  Reset: state=IDLE. All outputs 0. instret=0. Wait counter=0. Reset mid-transaction abandons it;
//   mem_req drops asynchronously.
//  IDLE -> FETCH unconditionally after 1 cycle.
//  FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ack: ir_we=1 that cycle, -> DECODE.
//  DECODE (1 cycle): valid opcodes are 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH,
//   0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR. Valid -> EXEC; anything else -> TRAP with illegal=1.
//  EXEC (1 cycle) ALU selects per class (a_sel/b_sel/alu_op):
//   R=0/0/1; I-ALU=0/1/1; LOAD,STORE,JALR=0/1/0; LUI=2/1/0; AUIPC=1/1/0; BRANCH=0/0/2; JAL: don't-care.
//   BRANCH completes in EXEC: pc_we=1, pc_src=br_taken?1:0, retire=1, -> FETCH.
//   LOAD/STORE -> MEM. All others -> WB.
//  MEM: mem_req=1, addr_sel=1, mem_we=(STORE). ALU result held by datapath register.
//   On mem_ack: STORE completes (pc_we=1, pc_src=0, retire=1, -> FETCH); LOAD -> WB (MDR captured on ack).
//  WB (1 cycle): rf_we=1, pc_we=1, retire=1, -> FETCH. wb_sel: LOAD=1, JAL/JALR=2, else 0.
//   pc_src: JAL=1, JALR=2, else 0.
//  Wait counter: cleared on entry to FETCH/MEM. Increments each cycle mem_req=1 && !mem_ack.
//   Reaching MEM_TIMEOUT -> TRAP, bus_err=1, mem_req drops next cycle. mem_ack on the same cycle wins (no error).
//  TRAP: all enables/req 0. Held until rst_n low. Flags remain sticky.
//  instret += 1 on each retire, modulo 2^INSTRET_W.
//  Latency with zero-wait mem (ack in first request cycle): BRANCH 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4,
//   STORE 4, LOAD 5.
//  mem_ack outside FETCH/MEM is ignored.
// TESTING
//  1 Reset release, opcode=0110011, ack immediate -> IDLE,FETCH,DECODE,EXEC,WB; rf_we/pc_we/retire in cycle 5;
//    instret=1.
//  2 LOAD with ack delayed 3 cycles in MEM -> mem_req high 4 cycles, addr_sel=1, rf_we with wb_sel=1,
//    total 8 cycles.
//  3 BRANCH br_taken=1 then br_taken=0 -> pc_src=1 then 0, pc_we in EXEC, no rf_we, 3 cycles each.
//  4 opcode=0000000 -> TRAP, illegal=1, no pc_we/rf_we/retire. Stays until reset; after reset illegal=0.
//  5 MEM_TIMEOUT=4, mem_ack never in FETCH -> bus_err=1 after 4 waiting cycles, mem_req=0, TRAP held.
//    Ack on 4th cycle -> no error.
//  6 rst_n low mid-MEM of STORE -> mem_req/mem_we 0 immediately, instret=0, restart from IDLE.
//    INSTRET_W=3: 9 retires -> instret=1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Memory-port handshake between the multi-cycle controller and the shared memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath and single memory port, counts retired instructions and
// traps on illegal opcodes or memory timeouts.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 br_taken,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_a_sel,
  output logic                 alu_b_sel,
  output logic [1:0]           alu_op,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal,
  output logic                 bus_err
);

  localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    st_idle,
    st_fetch,
    st_decode,
    st_exec,
    st_mem,
    st_wb,
    st_trap
  } state_t;

  typedef enum logic [3:0] {
    cls_r,
    cls_i,
    cls_load,
    cls_store,
    cls_branch,
    cls_lui,
    cls_auipc,
    cls_jal,
    cls_jalr,
    cls_bad
  } cls_t;

  state_t           state_q;
  state_t           state_d;
  cls_t             cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_last;
  logic             illegal_q;
  logic             bus_err_q;

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  // An unanswered request in its final allowed cycle; a same-cycle ack wins.
  assign wait_last = mem.mem_req && !mem.mem_ack && (wait_cnt == CNT_LAST);

  // Classify the opcode currently held in IR.
  always_comb begin
    case (opcode)
      7'b0110011: cls = cls_r;
      7'b0010011: cls = cls_i;
      7'b0000011: cls = cls_load;
      7'b0100011: cls = cls_store;
      7'b1100011: cls = cls_branch;
      7'b0110111: cls = cls_lui;
      7'b0010111: cls = cls_auipc;
      7'b1101111: cls = cls_jal;
      7'b1100111: cls = cls_jalr;
      default:    cls = cls_bad;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= st_idle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle:   state_d = st_fetch;
      st_fetch: begin
        if (mem.mem_ack)    state_d = st_decode;
        else if (wait_last) state_d = st_trap;
      end
      st_decode: state_d = (cls == cls_bad) ? st_trap : st_exec;
      st_exec: begin
        case (cls)
          cls_branch:          state_d = st_fetch;
          cls_load, cls_store: state_d = st_mem;
          default:             state_d = st_wb;
        endcase
      end
      st_mem: begin
        if (mem.mem_ack)    state_d = (cls == cls_store) ? st_fetch : st_wb;
        else if (wait_last) state_d = st_trap;
      end
      st_wb:     state_d = st_fetch;
      st_trap:   state_d = st_trap;
      default:   state_d = st_idle;
    endcase
  end

  // Datapath controls decoded from state and instruction class.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    alu_op       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 2'd0;
    retire       = 1'b0;
    case (state_q)
      st_fetch: begin
        mem.mem_req = 1'b1;
        ir_we       = mem.mem_ack;
      end
      st_exec: begin
        case (cls)
          cls_r: alu_op = 2'd1;
          cls_i: begin
            alu_b_sel = 1'b1;
            alu_op    = 2'd1;
          end
          cls_load, cls_store, cls_jalr: alu_b_sel = 1'b1;
          cls_lui: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 1'b1;
          end
          cls_auipc: begin
            alu_a_sel = 2'd1;
            alu_b_sel = 1'b1;
          end
          cls_branch: begin
            alu_op = 2'd2;
            pc_we  = 1'b1;
            pc_src = br_taken ? 2'd1 : 2'd0;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      st_mem: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (cls == cls_store);
        if (mem.mem_ack && cls == cls_store) begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end
      st_wb: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        case (cls)
          cls_load: wb_sel = 2'd1;
          cls_jal: begin
            wb_sel = 2'd2;
            pc_src = 2'd1;
          end
          cls_jalr: begin
            wb_sel = 2'd2;
            pc_src = 2'd2;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Memory wait counter: counts unanswered request cycles, zero whenever no request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           wait_cnt <= '0;
    else if (mem.mem_req && !mem.mem_ack) wait_cnt <= wait_cnt + 1'b1;
    else                                  wait_cnt <= '0;
  end

  // Sticky trap flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == st_decode && cls == cls_bad) illegal_q <= 1'b1;
      if (wait_last)                              bus_err_q <= 1'b1;
    end
  end

  // Retired-instruction counter, wrapping at 2^INSTRET_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: randomized instruction streams with
// randomized memory latency, checked cycle by cycle against a phase-level model.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned IW = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] PH_F = 3'd0;
  localparam logic [2:0] PH_D = 3'd1;
  localparam logic [2:0] PH_E = 3'd2;
  localparam logic [2:0] PH_M = 3'd3;
  localparam logic [2:0] PH_W = 3'd4;
  localparam logic [2:0] PH_T = 3'd5;

  typedef struct packed {
    logic       req;
    logic       we;
    logic       addr;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
  } ctl_t;

  typedef struct packed {
    logic       ack;
    logic       real_op;
    logic [2:0] ph;
    ctl_t       exp;
    ctl_t       mask;
  } step_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    opcode;
  logic          br_taken;
  logic          ir_we;
  logic          pc_we;
  logic [1:0]    pc_src;
  logic [1:0]    alu_a_sel;
  logic          alu_b_sel;
  logic [1:0]    alu_op;
  logic          rf_we;
  logic [1:0]    wb_sel;
  logic          retire;
  logic [IW-1:0] instret;
  logic          illegal;
  logic          bus_err;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT(TO),
    .INSTRET_W  (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .br_taken (br_taken),
    .mem      (bus),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .pc_src   (pc_src),
    .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel),
    .alu_op   (alu_op),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .retire   (retire),
    .instret  (instret),
    .illegal  (illegal),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_instret = 0;
  step_t plan_q[$];
  ctl_t  obs_q[$];

  function automatic ctl_t observe();
    ctl_t c;
    c.req    = bus.mem_req;
    c.we     = bus.mem_we;
    c.addr   = bus.addr_sel;
    c.ir_we  = ir_we;
    c.pc_we  = pc_we;
    c.pc_src = pc_src;
    c.a_sel  = alu_a_sel;
    c.b_sel  = alu_b_sel;
    c.alu_op = alu_op;
    c.rf_we  = rf_we;
    c.wb_sel = wb_sel;
    c.retire = retire;
    return c;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  endfunction

  function automatic logic [6:0] rand_legal();
    logic [6:0] ops [9];
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    return ops[$urandom_range(0, 8)];
  endfunction

  function automatic string phase_name(input logic [2:0] ph);
    case (ph)
      PH_F:    return "fetch";
      PH_D:    return "decode";
      PH_E:    return "exec";
      PH_M:    return "mem";
      PH_W:    return "wb";
      default: return "trap";
    endcase
  endfunction

  function automatic logic [IW-1:0] exp_cnt();
    return IW'(exp_instret % (1 << IW));
  endfunction

  // Reference model: the expected per-cycle controls of one instruction, phase by phase.
  task automatic build_plan(input logic [6:0] op, input logic br, input int unsigned wf,
                            input int unsigned wm, input int unsigned trap_len);
    step_t s;
    plan_q.delete();
    for (int unsigned i = 0; i <= wf; i++) begin
      s = '0; s.mask = '1; s.ph = PH_F; s.ack = (i == wf);
      s.exp.req = 1'b1; s.exp.ir_we = (i == wf);
      plan_q.push_back(s);
    end
    s = '0; s.mask = '1; s.ph = PH_D; s.real_op = 1'b1; s.ack = 1'($urandom);
    plan_q.push_back(s);
    if (!is_legal(op)) begin
      for (int unsigned i = 0; i < trap_len; i++) begin
        s = '0; s.mask = '1; s.ph = PH_T; s.real_op = 1'b1; s.ack = 1'($urandom);
        plan_q.push_back(s);
      end
      return;
    end
    s = '0; s.mask = '1; s.ph = PH_E; s.real_op = 1'b1; s.ack = 1'($urandom);
    case (op)
      OP_R:                      s.exp.alu_op = 2'd1;
      OP_I:                      begin s.exp.b_sel = 1'b1; s.exp.alu_op = 2'd1; end
      OP_LOAD, OP_STORE, OP_JALR: s.exp.b_sel = 1'b1;
      OP_LUI:                    begin s.exp.a_sel = 2'd2; s.exp.b_sel = 1'b1; end
      OP_AUIPC:                  begin s.exp.a_sel = 2'd1; s.exp.b_sel = 1'b1; end
      OP_BRANCH: begin
        s.exp.alu_op = 2'd2; s.exp.pc_we = 1'b1; s.exp.retire = 1'b1;
        s.exp.pc_src = br ? 2'd1 : 2'd0;
      end
      default: begin
        s.mask.a_sel = '0; s.mask.b_sel = 1'b0; s.mask.alu_op = '0;
      end
    endcase
    plan_q.push_back(s);
    if (op == OP_BRANCH) return;
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int unsigned j = 0; j <= wm; j++) begin
        s = '0; s.mask = '1; s.ph = PH_M; s.real_op = 1'b1; s.ack = (j == wm);
        s.exp.req = 1'b1; s.exp.addr = 1'b1; s.exp.we = (op == OP_STORE);
        if (op == OP_STORE && j == wm) begin
          s.exp.pc_we = 1'b1; s.exp.retire = 1'b1;
        end
        plan_q.push_back(s);
      end
      if (op == OP_STORE) return;
    end
    s = '0; s.mask = '1; s.ph = PH_W; s.real_op = 1'b1; s.ack = 1'($urandom);
    s.exp.rf_we = 1'b1; s.exp.pc_we = 1'b1; s.exp.retire = 1'b1;
    s.exp.wb_sel = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
    s.exp.pc_src = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
    plan_q.push_back(s);
  endtask

  task automatic drive_cycle(input logic ack, input logic [6:0] op, input logic br);
    @(negedge clk);
    bus.mem_ack = ack;
    opcode      = op;
    br_taken    = br;
    #1;
  endtask

  // Plays the plan against the DUT, recording observed controls; ends just after the closing edge.
  task automatic run_plan(input logic [6:0] op, input logic br);
    obs_q.delete();
    foreach (plan_q[k]) begin
      logic [6:0] opv;
      logic       brv;
      opv = plan_q[k].real_op ? op : 7'($urandom);
      brv = (plan_q[k].ph == PH_E) ? br : 1'($urandom);
      drive_cycle(plan_q[k].ack, opv, brv);
      obs_q.push_back(observe());
    end
    if (is_legal(op)) exp_instret++;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    exp_instret = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.mem_ack = 1'b0; opcode = OP_R; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (observe() !== ctl_t'('0) || instret !== '0 || illegal !== 1'b0 || bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ctl=%h instret=%0d illegal=%b bus_err=%b, required all 0",
               observe(), instret, illegal, bus_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 0;
    #1;
    vectors++;
    if (observe() !== ctl_t'('0)) begin
      miscompares++;
      $display("FAIL idle_ctl: got %h required 0", observe());
    end
  endtask

  task automatic test_alu_wb();
    build_plan(OP_R, 1'b0, 0, 0, 0);
    run_plan(OP_R, 1'b0);
    foreach (plan_q[k]) begin
      vectors++;
      if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
        miscompares++;
        $display("FAIL alu_wb[%0d] %s: got %h required %h", k, phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
      end
    end
    vectors++;
    if (instret !== IW'(1)) begin
      miscompares++;
      $display("FAIL alu_wb_instret: got %0d required 1", instret);
    end
  endtask

  task automatic test_load_wait();
    int req_cycles;
    build_plan(OP_LOAD, 1'b0, 0, 3, 0);
    run_plan(OP_LOAD, 1'b0);
    req_cycles = 0;
    foreach (plan_q[k]) begin
      if (plan_q[k].ph == PH_M && obs_q[k].req) req_cycles++;
      vectors++;
      if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
        miscompares++;
        $display("FAIL load_wait[%0d] %s: got %h required %h", k, phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
      end
    end
    vectors++;
    if (req_cycles != 4 || instret !== exp_cnt()) begin
      miscompares++;
      $display("FAIL load_wait_totals: mem_req cycles=%0d instret=%0d required 4 and %0d",
               req_cycles, instret, exp_cnt());
    end
  endtask

  task automatic test_branch();
    for (int b = 1; b >= 0; b--) begin
      build_plan(OP_BRANCH, 1'(b), $urandom_range(0, 1), 0, 0);
      run_plan(OP_BRANCH, 1'(b));
      foreach (plan_q[k]) begin
        vectors++;
        if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
          miscompares++;
          $display("FAIL branch_t%0d[%0d] %s: got %h required %h", b, k, phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
        end
      end
      vectors++;
      if (instret !== exp_cnt()) begin
        miscompares++;
        $display("FAIL branch_instret: got %0d required %0d", instret, exp_cnt());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [6:0] op;
      logic       br;
      op = rand_legal();
      br = 1'($urandom);
      build_plan(op, br, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 0);
      run_plan(op, br);
      foreach (plan_q[k]) begin
        vectors++;
        if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
          miscompares++;
          $display("FAIL random#%0d op=%b [%0d] %s: got %h required %h", n, op, k,
                   phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
        end
      end
      vectors++;
      if (instret !== exp_cnt() || bus_err !== 1'b0 || illegal !== 1'b0) begin
        miscompares++;
        $display("FAIL random#%0d status: instret=%0d bus_err=%b illegal=%b required %0d,0,0",
                 n, instret, bus_err, illegal, exp_cnt());
      end
    end
  endtask

  task automatic test_instret_wrap();
    apply_reset();
    for (int n = 0; n < 9; n++) begin
      logic br;
      br = 1'($urandom);
      build_plan(OP_BRANCH, br, 0, 0, 0);
      run_plan(OP_BRANCH, br);
    end
    vectors++;
    if (instret !== IW'(1)) begin
      miscompares++;
      $display("FAIL instret_wrap: got %0d required 1", instret);
    end
  endtask

  task automatic test_illegal();
    logic [6:0] op;
    do op = 7'($urandom); while (is_legal(op));
    build_plan(op, 1'b0, $urandom_range(0, 2), 0, 5);
    run_plan(op, 1'b0);
    foreach (plan_q[k]) begin
      vectors++;
      if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
        miscompares++;
        $display("FAIL illegal op=%b [%0d] %s: got %h required %h", op, k, phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
      end
    end
    vectors++;
    if (illegal !== 1'b1 || bus_err !== 1'b0 || instret !== exp_cnt()) begin
      miscompares++;
      $display("FAIL illegal_flags: illegal=%b bus_err=%b instret=%0d required 1,0,%0d",
               illegal, bus_err, instret, exp_cnt());
    end
    apply_reset();
    vectors++;
    if (illegal !== 1'b0 || observe() !== ctl_t'('0)) begin
      miscompares++;
      $display("FAIL illegal_after_reset: illegal=%b ctl=%h required 0", illegal, observe());
    end
  endtask

  task automatic test_timeout();
    // Fetch never acknowledged.
    apply_reset();
    for (int i = 0; i < int'(TO); i++) begin
      drive_cycle(1'b0, 7'($urandom), 1'b0);
      vectors++;
      if (bus.mem_req !== 1'b1 || bus_err !== 1'b0) begin
        miscompares++;
        $display("FAIL fetch_wait%0d: mem_req=%b bus_err=%b required 1,0", i, bus.mem_req, bus_err);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'($urandom), OP_R, 1'b0);
      vectors++;
      if (observe() !== ctl_t'('0) || bus_err !== 1'b1) begin
        miscompares++;
        $display("FAIL fetch_timeout_trap%0d: ctl=%h bus_err=%b required 0,1", i, observe(), bus_err);
      end
    end
    // Store address phase never acknowledged.
    apply_reset();
    drive_cycle(1'b1, 7'($urandom), 1'b0);
    drive_cycle(1'b0, OP_STORE, 1'b0);
    drive_cycle(1'b0, OP_STORE, 1'b0);
    for (int i = 0; i < int'(TO); i++) begin
      drive_cycle(1'b0, OP_STORE, 1'b0);
      vectors++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus_err !== 1'b0) begin
        miscompares++;
        $display("FAIL mem_wait%0d: mem_req=%b mem_we=%b bus_err=%b required 1,1,0",
                 i, bus.mem_req, bus.mem_we, bus_err);
      end
    end
    drive_cycle(1'b1, OP_STORE, 1'b0);
    vectors++;
    if (observe() !== ctl_t'('0) || bus_err !== 1'b1 || instret !== '0) begin
      miscompares++;
      $display("FAIL mem_timeout_trap: ctl=%h bus_err=%b instret=%0d required 0,1,0", observe(), bus_err, instret);
    end
    // Acks arriving in the last allowed cycle are accepted.
    apply_reset();
    build_plan(OP_LOAD, 1'b0, TO - 1, TO - 1, 0);
    run_plan(OP_LOAD, 1'b0);
    foreach (plan_q[k]) begin
      vectors++;
      if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
        miscompares++;
        $display("FAIL late_ack[%0d] %s: got %h required %h", k, phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
      end
    end
    vectors++;
    if (bus_err !== 1'b0 || instret !== exp_cnt()) begin
      miscompares++;
      $display("FAIL late_ack_status: bus_err=%b instret=%0d required 0,%0d", bus_err, instret, exp_cnt());
    end
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    build_plan(OP_BRANCH, 1'b1, 0, 0, 0);
    run_plan(OP_BRANCH, 1'b1);
    drive_cycle(1'b1, 7'($urandom), 1'b0);
    drive_cycle(1'b0, OP_STORE, 1'b0);
    drive_cycle(1'b0, OP_STORE, 1'b0);
    drive_cycle(1'b0, OP_STORE, 1'b0);
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.addr_sel !== 1'b1) begin
      miscompares++;
      $display("FAIL store_mem_phase: req=%b we=%b addr_sel=%b required 1,1,1", bus.mem_req, bus.mem_we, bus.addr_sel);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || instret !== '0) begin
      miscompares++;
      $display("FAIL async_reset: req=%b we=%b instret=%0d required 0,0,0", bus.mem_req, bus.mem_we, instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_instret = 0;
    #1;
    build_plan(OP_JALR, 1'b0, 1, 0, 0);
    run_plan(OP_JALR, 1'b0);
    foreach (plan_q[k]) begin
      vectors++;
      if ((obs_q[k] & plan_q[k].mask) !== (plan_q[k].exp & plan_q[k].mask)) begin
        miscompares++;
        $display("FAIL restart[%0d] %s: got %h required %h", k, phase_name(plan_q[k].ph), obs_q[k], plan_q[k].exp);
      end
    end
    vectors++;
    if (instret !== IW'(1)) begin
      miscompares++;
      $display("FAIL restart_instret: got %0d required 1", instret);
    end
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_load_wait();
    test_branch();
    test_random();
    test_instret_wrap();
    test_illegal();
    test_timeout();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
